// File: rtl/hash_display_scanner.sv
// Captures the SHA-256 digest once and pages it across an 8-digit seven-segment display.
// Latency: outputs registered, one cycle behind internal state; no backpressure, display sink only.
module hash_display_scanner #(
  parameter int           SCAN_BITS   = 17,
  parameter int           PAGE_CYCLES = 100000000,
  parameter logic [255:0] EXPECTED    = 256'hB94D27B9934D3E08A52E52D7DA7DABFAC484EFE37A5380EE9088F7ACE2EFCDE9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         finished,
  input  logic [255:0] hash_value,
  input  logic         next_page,
  output logic         A,
  output logic         B,
  output logic         C,
  output logic         D,
  output logic         E,
  output logic         F,
  output logic         G,
  output logic         an0,
  output logic         an1,
  output logic         an2,
  output logic         an3,
  output logic         an4,
  output logic         an5,
  output logic         an6,
  output logic         an7,
  output logic         done_LED,
  output logic         match_LED,
  output logic [2:0]   page_LED
);

  localparam int            TW         = $clog2(PAGE_CYCLES);
  localparam int            SW         = SCAN_BITS + 3;
  localparam logic [TW-1:0] TIMER_LAST = TW'(PAGE_CYCLES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t         state_q, state_d;
  logic [255:0]   hold_q;
  logic           match_q;
  logic [2:0]     page_q;
  logic [TW-1:0]  timer_q;
  logic           btn_q;
  logic [SW-1:0]  scan_q;
  logic [6:0]     seg_q;
  logic [7:0]     an_q;
  logic           done_q;
  logic           match_led_q;
  logic [2:0]     page_led_q;

  logic           capture;
  logic           press;
  logic           advance;
  logic [2:0]     digit;
  logic [31:0]    page_word;
  logic [3:0]     nibble;

  // Lit segments as {A,B,C,D,E,F,G}, 1 = lit; inverted on the way out.
  function automatic logic [6:0] hex_lit(input logic [3:0] n);
    case (n)
      4'h0: hex_lit = 7'b1111110;
      4'h1: hex_lit = 7'b0110000;
      4'h2: hex_lit = 7'b1101101;
      4'h3: hex_lit = 7'b1111001;
      4'h4: hex_lit = 7'b0110011;
      4'h5: hex_lit = 7'b1011011;
      4'h6: hex_lit = 7'b1011111;
      4'h7: hex_lit = 7'b1110000;
      4'h8: hex_lit = 7'b1111111;
      4'h9: hex_lit = 7'b1111011;
      4'hA: hex_lit = 7'b1110111;
      4'hB: hex_lit = 7'b0011111;
      4'hC: hex_lit = 7'b1001110;
      4'hD: hex_lit = 7'b0111101;
      4'hE: hex_lit = 7'b1001111;
      default: hex_lit = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    press   = next_page & ~btn_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (finished) begin
          capture = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: advance = press | (timer_q == TIMER_LAST);
      default: state_d = IDLE;
    endcase
  end

  // Page 0 is the most significant word, so the shift is (7 - page) words.
  assign digit     = scan_q[SW-1:SCAN_BITS];
  assign page_word = 32'(hold_q >> {~page_q, 5'd0});
  assign nibble    = page_word[{digit, 2'b00} +: 4];

  always_ff @(posedge clock) begin
    if (capture) hold_q <= hash_value;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      match_q <= 1'b0;
      page_q  <= 3'd0;
      timer_q <= '0;
      btn_q   <= 1'b0;
      scan_q  <= '0;
    end else begin
      state_q <= state_d;
      btn_q   <= next_page;
      scan_q  <= scan_q + 1'b1;
      if (capture) begin
        match_q <= (hash_value == EXPECTED);
        page_q  <= 3'd0;
        timer_q <= '0;
      end else if (state_q == SHOW) begin
        if (advance) begin
          page_q  <= page_q + 3'd1;
          timer_q <= '0;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || state_q != SHOW) begin
      seg_q       <= 7'h7F;
      an_q        <= 8'hFF;
      done_q      <= 1'b0;
      match_led_q <= 1'b0;
      page_led_q  <= 3'd0;
    end else begin
      seg_q       <= ~hex_lit(nibble);
      an_q        <= ~(8'b1 << digit);
      done_q      <= 1'b1;
      match_led_q <= match_q;
      page_led_q  <= page_q;
    end
  end

  assign {A, B, C, D, E, F, G}                  = seg_q;
  assign {an7, an6, an5, an4, an3, an2, an1, an0} = an_q;
  assign done_LED  = done_q;
  assign match_LED = match_led_q;
  assign page_LED  = page_led_q;

endmodule

// File: tb/tb_hash_display_scanner.sv
// Directed scenarios plus randomized traffic, checked against a cycle-level behavioural model.
module tb_hash_display_scanner;

  localparam int           SB  = 2;
  localparam int           PC  = 50;
  localparam logic [255:0] EXP = 256'hB94D27B9934D3E08A52E52D7DA7DABFAC484EFE37A5380EE9088F7ACE2EFCDE9;

  logic         clock = 1'b0;
  logic         reset, finished, next_page;
  logic [255:0] hash_value;
  logic         A, B, C, D, E, F, G;
  logic         an0, an1, an2, an3, an4, an5, an6, an7;
  logic         done_LED, match_LED;
  logic [2:0]   page_LED;
  logic [6:0]   seg;
  logic [7:0]   an;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  hash_display_scanner #(.SCAN_BITS(SB), .PAGE_CYCLES(PC), .EXPECTED(EXP)) dut (
    .clock(clock), .reset(reset), .finished(finished), .hash_value(hash_value),
    .next_page(next_page),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
    .an0(an0), .an1(an1), .an2(an2), .an3(an3), .an4(an4), .an5(an5), .an6(an6), .an7(an7),
    .done_LED(done_LED), .match_LED(match_LED), .page_LED(page_LED)
  );

  assign seg = {A, B, C, D, E, F, G};
  assign an  = {an7, an6, an5, an4, an3, an2, an1, an0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Lit-segment letters per hex digit, straight from the decode table.
  string seg_tbl [16] = '{"ABCDEF", "BC", "ABDEG", "ABCDG", "BCFG", "ACDFG", "ACDEFG", "ABC",
                          "ABCDEFG", "ABCDFG", "ABCEFG", "CDEFG", "ADEF", "BCDEG", "ADEFG", "AEFG"};

  function automatic logic [6:0] seg_of(input int v);
    string      s = seg_tbl[v];
    logic [6:0] r = 7'h7F;
    for (int i = 0; i < s.len(); i++) r[6 - (int'(s[i]) - 65)] = 1'b0;
    return r;
  endfunction

  // Behavioural model: integer cycle counts, page age and a captured digest.
  bit           model_on = 0;
  bit           m_show, m_match, m_prev_btn;
  logic [255:0] m_dig;
  int           m_page, m_age, m_cyc;
  logic [6:0]   e_seg;
  logic [7:0]   e_an;
  logic         e_done, e_match;
  logic [2:0]   e_page;

  always @(posedge clock) begin
    if (reset) begin
      model_on = 1;
      m_show = 0; m_page = 0; m_age = 0; m_cyc = 0; m_prev_btn = 0;
      e_seg = 7'h7F; e_an = 8'hFF; e_done = 0; e_match = 0; e_page = 0;
    end else if (model_on) begin
      int           d;
      logic [255:0] sh;
      d = (m_cyc / (1 << SB)) % 8;
      if (m_show) begin
        sh      = m_dig >> (32 * (7 - m_page));
        e_an    = 8'hFF;
        e_an[d] = 1'b0;
        e_seg   = seg_of(int'((sh[31:0] >> (4 * d)) & 32'hF));
        e_done  = 1; e_match = m_match; e_page = 3'(m_page);
      end else begin
        e_seg = 7'h7F; e_an = 8'hFF; e_done = 0; e_match = 0; e_page = 0;
      end
      if (!m_show) begin
        if (finished) begin
          m_show = 1; m_dig = hash_value; m_match = (hash_value == EXP);
          m_page = 0; m_age = 0;
        end
      end else if ((next_page && !m_prev_btn) || m_age == PC - 1) begin
        m_page = (m_page + 1) % 8;
        m_age  = 0;
      end else begin
        m_age++;
      end
      m_prev_btn = next_page;
      m_cyc++;
    end
  end

  always @(negedge clock)
    if (model_on)
      chk("cycle", {seg, an, done_LED, match_LED, page_LED}, {e_seg, e_an, e_done, e_match, e_page});

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press();
    next_page = 1'b1; tick(2);
    next_page = 1'b0; tick(2);
  endtask

  task automatic scan_page(input logic [31:0] w, input string tag);
    logic [6:0] got [8];
    for (int k = 0; k < 8; k++) got[k] = 7'h7F;
    repeat (40) begin
      tick(1);
      for (int k = 0; k < 8; k++) if (an == ~(8'b1 << k)) got[k] = seg;
    end
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_an%0d", tag, k), got[k], seg_of(int'(w[4*k +: 4])));
  endtask

  function automatic logic [255:0] rand_hash();
    logic [255:0] h;
    for (int j = 0; j < 8; j++) h[32*j +: 32] = $urandom;
    return h;
  endfunction

  initial begin
    int n;
    reset = 1'b1; finished = 1'b0; next_page = 1'b0; hash_value = '0;
    tick(3);
    chk("reset_outs", {seg, an, done_LED, match_LED, page_LED}, {7'h7F, 8'hFF, 5'd0});

    // Capture the golden digest.
    reset = 1'b0; hash_value = EXP; finished = 1'b1;
    tick(1);
    finished = 1'b0;
    chk("done_at_capture_edge", done_LED, 0);
    tick(1);
    chk("done_after_capture", done_LED, 1);
    chk("match_after_capture", match_LED, 1);
    chk("blank_B_digit", seg_of(11), 7'b1100000);
    scan_page(32'hB94D27B9, "page0");

    // Button edge, then a long hold: only timer expiries advance.
    next_page = 1'b1;
    tick(2);
    chk("page_after_press", page_LED, 1);
    scan_page(32'h934D3E08, "page1");
    tick(159);
    chk("page_after_hold", page_LED, 4);
    next_page = 1'b0;

    // Auto-advance wrap 7 -> 0, then press coincident with timer expiry.
    n = 0;
    while (page_LED != 3'd7 && n < 400) begin tick(1); n++; end
    chk("wait_page7", page_LED, 7);
    tick(50);
    chk("wrap_to_0", page_LED, 0);
    tick(48);
    chk("before_expiry", page_LED, 0);
    next_page = 1'b1;
    tick(2);
    chk("coincident_one_adv", page_LED, 1);
    next_page = 1'b0;
    tick(48);
    chk("timer_restart", page_LED, 1);
    tick(2);
    chk("next_auto_adv", page_LED, 2);

    // Mismatching digest, one capture per reset.
    reset = 1'b1; tick(1);
    reset = 1'b0; hash_value = EXP ^ 256'd1; finished = 1'b1;
    tick(1);
    finished = 1'b0;
    tick(1);
    chk("mismatch_done", done_LED, 1);
    chk("mismatch_match", match_LED, 0);
    repeat (7) press();
    hash_value = rand_hash(); finished = 1'b1;
    tick(1);
    finished = 1'b0;
    chk("recapture_ignored_page", page_LED, 7);
    chk("recapture_ignored_match", match_LED, 0);
    scan_page(32'hE2EFCDE8, "page7");

    // Reset mid-SHOW at page 5, finished held through reset.
    n = 0;
    while (page_LED != 3'd5 && n < 20) begin press(); n++; end
    chk("reach_page5", page_LED, 5);
    reset = 1'b1; hash_value = EXP; finished = 1'b1;
    tick(1);
    chk("reset_midshow", {seg, an, done_LED, match_LED, page_LED}, {7'h7F, 8'hFF, 5'd0});
    reset = 1'b0;
    tick(2);
    finished = 1'b0;
    chk("fresh_capture_done", done_LED, 1);
    chk("fresh_capture_page", page_LED, 0);
    chk("fresh_capture_match", match_LED, 1);

    // Random traffic; the per-cycle model comparison does the checking.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) next_page = ~next_page;
      finished   = ($urandom_range(63) == 0);
      hash_value = $urandom_range(1) ? EXP : rand_hash();
      reset      = ($urandom_range(399) == 0);
      tick(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
